// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Initiator side of the data-memory port, between the pipeline MEM stage and
//   a byte-addressed data memory whose port always reads/writes 8 bytes.
//   Loads extract and sign/zero-extend the low 1/2/4/8 bytes of the read.
//   Stores narrower than 8 bytes do a read-modify-write so that the bytes
//   outside the access are written back unchanged.
//
// Parameters
//   MEM_BYTES  size of the attached memory in bytes (range check)
//   ADDR_W     width of request and memory addresses
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_write/size/unsigned     store flag, size (0=B,1=H,2=W,3=D), zero-extend
//   req_addr, req_wdata         byte address, store data (low bytes used)
//   resp_valid/resp_ready       response handshake (held until accepted)
//   resp_data, resp_fault       extended load data (0 for stores/faults), fault
//   mem_address                 address to memory
//   mem_write_data              8 bytes to write
//   mem_memorywrite             write strobe (8 bytes on posedge)
//   mem_memoryread              read enable (mem_read_data is combinational)
//   mem_read_data               bytes [addr+7 .. addr]
//
// Build option
//   MISALIGN_FAULT_EN  when defined, accesses not aligned to their size fault.
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int MEM_BYTES = 64,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_data,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_address,
  output logic [63:0]       mem_write_data,
  output logic              mem_memorywrite,
  output logic              mem_memoryread,
  input  logic [63:0]       mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LD     = 3'd1,
    S_RMW_RD = 3'd2,
    S_WR     = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  // Highest legal start address: the port always touches 8 bytes.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 8);

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [63:0]         r_wdata;
  logic [63:0]         r_merge;
  logic [63:0]         r_resp_data;
  logic                r_resp_fault;

  logic                w_accept;
  logic                w_fault;
  logic                w_range_fault;
  logic [63:0]         w_merged;
`ifdef MISALIGN_FAULT_EN
  logic [ADDR_W-1:0]   w_align_mask;
  logic                w_misalign;
`endif

  // Low 2^size bytes of d, sign- or zero-extended to 64 bits.
  function automatic logic [63:0] f_extend(input logic [63:0] d,
                                           input logic [1:0]  size,
                                           input logic        uns);
    case (size)
      2'd0:    f_extend = uns ? {56'd0, d[7:0]}  : {{56{d[7]}},  d[7:0]};
      2'd1:    f_extend = uns ? {48'd0, d[15:0]} : {{48{d[15]}}, d[15:0]};
      2'd2:    f_extend = uns ? {32'd0, d[31:0]} : {{32{d[31]}}, d[31:0]};
      default: f_extend = d;
    endcase
  endfunction

  // base with its low 2^size bytes replaced by the same bytes of wdata.
  function automatic logic [63:0] f_merge(input logic [63:0] base,
                                          input logic [63:0] wdata,
                                          input logic [1:0]  size);
    case (size)
      2'd0:    f_merge = {base[63:8],  wdata[7:0]};
      2'd1:    f_merge = {base[63:16], wdata[15:0]};
      2'd2:    f_merge = {base[63:32], wdata[31:0]};
      default: f_merge = wdata;
    endcase
  endfunction

  assign w_accept      = req_valid && (r_state == S_IDLE);
  assign w_range_fault = (req_addr > LAST_ADDR);

`ifdef MISALIGN_FAULT_EN
  // Alignment mask for the requested size; any set bit under it is misaligned.
  always_comb begin
    case (req_size)
      2'd0:    w_align_mask = ADDR_W'(0);
      2'd1:    w_align_mask = ADDR_W'(1);
      2'd2:    w_align_mask = ADDR_W'(3);
      default: w_align_mask = ADDR_W'(7);
    endcase
  end
  assign w_misalign = |(req_addr & w_align_mask);
  assign w_fault    = w_range_fault || w_misalign;
`else
  assign w_fault    = w_range_fault;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_fault) begin
            w_next = S_RESP;
          end else if (!req_write) begin
            w_next = S_LD;
          end else if (req_size == 2'd3) begin
            w_next = S_WR;
          end else begin
            w_next = S_RMW_RD;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_LD:     w_next = S_RESP;
      S_RMW_RD: w_next = S_WR;
      S_WR:     w_next = S_RESP;
      S_RESP: begin
        if (resp_ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_RESP;
        end
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Request latch, merge capture and response data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_size       <= 2'd0;
      r_unsigned   <= 1'b0;
      r_mem_addr   <= '0;
      r_wdata      <= 64'd0;
      r_merge      <= 64'd0;
      r_resp_data  <= 64'd0;
      r_resp_fault <= 1'b0;
    end else if (w_accept) begin
      r_size       <= req_size;
      r_unsigned   <= req_unsigned;
      r_wdata      <= req_wdata;
      r_resp_data  <= 64'd0;
      r_resp_fault <= w_fault;
      // A faulting request never drives the port, so the address holds.
      if (!w_fault) begin
        r_mem_addr <= req_addr;
      end else begin
        r_mem_addr <= r_mem_addr;
      end
    end else if (r_state == S_LD) begin
      r_resp_data <= f_extend(mem_read_data, r_size, r_unsigned);
    end else if (r_state == S_RMW_RD) begin
      r_merge <= mem_read_data;
    end else begin
      r_resp_data <= r_resp_data;
    end
  end

  // Size 3 never passes through RMW_RD, so the merge register is bypassed.
  assign w_merged = f_merge(r_merge, r_wdata, r_size);

  // Strobes come straight from state and are killed by reset in the same
  // cycle, so a reset landing on WR suppresses that write.
  assign mem_memoryread  = !reset && ((r_state == S_LD) || (r_state == S_RMW_RD));
  assign mem_memorywrite = !reset && (r_state == S_WR);
  assign mem_write_data  = (!reset && (r_state == S_WR)) ? w_merged : 64'd0;
  assign mem_address     = r_mem_addr;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_data  = r_resp_data;
  assign resp_fault = r_resp_fault;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//   Table of request vectors with expected response, latency, strobe counts
//   and write data; expectations are queued at accept and popped when the
//   response appears. Hand-written sequences cover reset values, a stalled
//   response and a reset landing on the write cycle.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic        resp_fault;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic        mem_memorywrite;
  logic        mem_memoryread;
  logic [63:0] mem_read_data;

  logic [7:0]  mem [0:63];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_data;
    logic        exp_fault;
    int          exp_lat;
    logic [63:0] exp_wd;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        fault;
    int          lat;
    int          rd;
    int          wr;
    logic [63:0] wd;
  } exp_t;

  exp_t sb[$];

  mem_access_unit #(.MEM_BYTES(64), .ADDR_W(64)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_data       (resp_data),
    .resp_fault      (resp_fault),
    .mem_address     (mem_address),
    .mem_write_data  (mem_write_data),
    .mem_memorywrite (mem_memorywrite),
    .mem_memoryread  (mem_memoryread),
    .mem_read_data   (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-addressed memory model: 8-byte little-endian port.
  always @(posedge clk) begin
    if (mem_memorywrite) begin
      for (int i = 0; i < 8; i++) begin
        mem[mem_address[5:0] + 6'(i)] <= mem_write_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    mem_read_data = 64'd0;
    for (int i = 0; i < 8; i++) begin
      mem_read_data[8*i +: 8] = mem[mem_address[5:0] + 6'(i)];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    exp_t        e;
    exp_t        got;
    int          cyc;
    int          rd;
    int          wr;
    logic [63:0] wd;
    logic        both;
    req_valid    = 1'b1;
    req_write    = v.wr;
    req_size     = v.sz;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 64'd0;
    req_wdata = 64'd0;
    e.data  = v.exp_data;
    e.fault = v.exp_fault;
    e.lat   = v.exp_lat;
    e.wd    = v.exp_wd;
    if (v.exp_fault) begin
      e.rd = 0; e.wr = 0;
    end else if (!v.wr) begin
      e.rd = 1; e.wr = 0;
    end else if (v.sz == 2'd3) begin
      e.rd = 0; e.wr = 1;
    end else begin
      e.rd = 1; e.wr = 1;
    end
    sb.push_back(e);
    cyc = 1; rd = 0; wr = 0; wd = 64'd0; both = 1'b0;
    while (cyc <= 20) begin
      if (mem_memoryread) rd++;
      if (mem_memorywrite) begin
        wr++;
        wd = mem_write_data;
      end
      if (mem_memoryread && mem_memorywrite) both = 1'b1;
      if (resp_valid) break;
      @(posedge clk);
      #1;
      cyc++;
    end
    got = sb.pop_front();
    chk($sformatf("v%0d_data", id),    resp_data,       got.data);
    chk($sformatf("v%0d_fault", id),   64'(resp_fault), 64'(got.fault));
    chk($sformatf("v%0d_latency", id), 64'(cyc),        64'(got.lat));
    chk($sformatf("v%0d_reads", id),   64'(rd),         64'(got.rd));
    chk($sformatf("v%0d_writes", id),  64'(wr),         64'(got.wr));
    chk($sformatf("v%0d_both_strobes", id), 64'(both),  64'd0);
    if (got.wr > 0) chk($sformatf("v%0d_wdata", id), wd, got.wd);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_resp_drop", id), 64'(resp_valid), 64'd0);
    chk($sformatf("v%0d_ready_again", id), 64'(req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[19];
    vec_t        v;
    int          cyc;
    logic [63:0] snap;

    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    for (int i = 8; i < 16; i++) mem[i] = 8'hFF;
    mem[16] = 8'hF0;
    mem[17] = 8'h80;
    mem[63] = 8'hA5;

    //          wr    sz    uns   addr    wdata                   exp_data                fault lat exp_wd
    vt[0]  = '{1'b1, 2'd3, 1'b0, 64'd0,  64'h1122334455667788, 64'h0,                  1'b0, 2, 64'h1122334455667788};
    vt[1]  = '{1'b0, 2'd3, 1'b0, 64'd0,  64'h0,                64'h1122334455667788,   1'b0, 2, 64'h0};
    vt[2]  = '{1'b1, 2'd0, 1'b0, 64'd8,  64'h123456789ABCDE5A, 64'h0,                  1'b0, 3, 64'hFFFFFFFFFFFFFF5A};
    vt[3]  = '{1'b0, 2'd3, 1'b1, 64'd8,  64'h0,                64'hFFFFFFFFFFFFFF5A,   1'b0, 2, 64'h0};
    vt[4]  = '{1'b0, 2'd1, 1'b0, 64'd16, 64'h0,                64'hFFFFFFFFFFFF80F0,   1'b0, 2, 64'h0};
    vt[5]  = '{1'b0, 2'd1, 1'b1, 64'd16, 64'h0,                64'h00000000000080F0,   1'b0, 2, 64'h0};
    vt[6]  = '{1'b0, 2'd0, 1'b0, 64'd16, 64'h0,                64'hFFFFFFFFFFFFFFF0,   1'b0, 2, 64'h0};
    vt[7]  = '{1'b0, 2'd3, 1'b0, 64'd57, 64'h0,                64'h0,                  1'b1, 1, 64'h0};
    vt[8]  = '{1'b0, 2'd3, 1'b0, 64'd56, 64'h0,                64'hA500000000000000,   1'b0, 2, 64'h0};
    vt[9]  = '{1'b1, 2'd2, 1'b0, 64'd20, 64'h55555555DEADBEEF, 64'h0,                  1'b0, 3, 64'h00000000DEADBEEF};
    vt[10] = '{1'b0, 2'd2, 1'b0, 64'd20, 64'h0,                64'hFFFFFFFFDEADBEEF,   1'b0, 2, 64'h0};
    vt[11] = '{1'b0, 2'd2, 1'b1, 64'd20, 64'h0,                64'h00000000DEADBEEF,   1'b0, 2, 64'h0};
    vt[12] = '{1'b1, 2'd1, 1'b0, 64'd18, 64'hAAAABBBBCCCC1234, 64'h0,                  1'b0, 3, 64'h0000DEADBEEF1234};
`ifdef MISALIGN_FAULT_EN
    vt[13] = '{1'b0, 2'd2, 1'b0, 64'd6,  64'h0,                64'h0,                  1'b1, 1, 64'h0};
`else
    vt[13] = '{1'b0, 2'd2, 1'b0, 64'd6,  64'h0,                64'hFFFFFFFFFF5A1122,   1'b0, 2, 64'h0};
`endif
    vt[14] = '{1'b1, 2'd0, 1'b0, 64'd60, 64'h00000000000000EE, 64'h0,                  1'b1, 1, 64'h0};
    vt[15] = '{1'b0, 2'd0, 1'b1, 64'd17, 64'h0,                64'h0000000000000080,   1'b0, 2, 64'h0};
    vt[16] = '{1'b0, 2'd0, 1'b0, 64'd17, 64'h0,                64'hFFFFFFFFFFFFFF80,   1'b0, 2, 64'h0};
    vt[17] = '{1'b0, 2'd3, 1'b0, 64'd16, 64'h0,                64'hDEADBEEF123480F0,   1'b0, 2, 64'h0};
    vt[18] = '{1'b0, 2'd3, 1'b1, 64'd0,  64'h0,                64'h1122334455667788,   1'b0, 2, 64'h0};

    // Reset values.
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 64'd0; req_wdata = 64'd0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid",  64'(resp_valid),      64'd0);
    chk("rst_resp_fault",  64'(resp_fault),      64'd0);
    chk("rst_wr_strobe",   64'(mem_memorywrite), 64'd0);
    chk("rst_rd_strobe",   64'(mem_memoryread),  64'd0);
    chk("rst_resp_data",   resp_data,            64'd0);
    chk("rst_mem_address", mem_address,          64'd0);
    chk("rst_mem_wdata",   mem_write_data,       64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_req_ready",   64'(req_ready),       64'd1);

    for (int i = 0; i < 19; i++) run_vec(i, vt[i]);

    // Stalled response: held stable, no new accept.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
    req_addr = 64'd0; resp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_addr = 64'd40;
    cyc = 1;
    while (!resp_valid && cyc <= 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("stall_latency", 64'(cyc), 64'd2);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall_valid_%0d", k), 64'(resp_valid), 64'd1);
      chk($sformatf("stall_data_%0d", k),  resp_data,       64'h1122334455667788);
      chk($sformatf("stall_ready_%0d", k), 64'(req_ready),  64'd0);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release_valid", 64'(resp_valid), 64'd0);
    chk("stall_release_ready", 64'(req_ready),  64'd1);

    // Reset landing on the WR cycle of a doubleword store.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3;
    req_addr = 64'd32; req_wdata = 64'hCAFEF00DCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("wrrst_strobe_before", 64'(mem_memorywrite), 64'd1);
    reset = 1'b1;
    #1;
    chk("wrrst_strobe_killed", 64'(mem_memorywrite), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("wrrst_idle",        64'(req_ready),  64'd1);
    chk("wrrst_resp_valid",  64'(resp_valid), 64'd0);
    chk("wrrst_mem_address", mem_address,     64'd0);
    snap = 64'd0;
    for (int i = 0; i < 8; i++) snap[8*i +: 8] = mem[32 + i];
    chk("wrrst_mem_unchanged", snap, 64'd0);
    @(posedge clk);
    #1;
    v = '{1'b0, 2'd3, 1'b0, 64'd0, 64'h0, 64'h1122334455667788, 1'b0, 2, 64'h0};
    run_vec(99, v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory port; sits between the pipeline MEM stage and the byte-addressed data memory.
- Accepts sized load/store requests (byte, half, word, doubleword).
- Loads: extracts the low bytes from the 8-byte read and sign- or zero-extends them.
- Stores narrower than 8 bytes: performs read-modify-write, because the memory port always writes 8 consecutive bytes.

Parameters:
- MEM_BYTES, 64, size of the attached data memory in bytes; used for the range check.
- ADDR_W, 64, width of request and memory addresses.

Ports:
- clk  input  1  clock; all state changes on the posedge.
- reset  input  1  synchronous active-high reset.
- req_valid  input  1  request offered.
- req_ready  output  1  unit can accept; high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned  input  1  load zero-extends when 1; ignored for stores.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  64  store data; the low bytes are used.
- resp_valid  output  1  response available; held until accepted.
- resp_ready  input  1  consumer accepts the response.
- resp_data  output  64  extended load result; 0 for stores and faults.
- resp_fault  output  1  access rejected.
- mem_address  output  ADDR_W  address to memory.
- mem_write_data  output  64  data to memory.
- mem_memorywrite  output  1  write strobe; memory writes 8 bytes on the posedge.
- mem_memoryread  output  1  read enable; mem_read_data is combinational.
- mem_read_data  input  64  bytes [addr+7 .. addr] from memory.

Behaviour:
- Reset values: state IDLE; resp_valid, resp_fault, mem_memorywrite and mem_memoryread all 0; resp_data, mem_address and mem_write_data all 0.
- Memory strobes are decoded from state and gated with !reset. A reset asserted during any cycle suppresses that cycle's write and aborts the operation; the unit is in IDLE the cycle after.
- Request handshake: a transfer happens on a posedge with req_valid && req_ready. On accept, the unit latches write, size, unsigned, addr and wdata; inputs are don't-care afterwards.
- Range check at accept: fault if req_addr > MEM_BYTES-8, because the port touches 8 bytes. A faulting request goes directly to RESP with resp_fault=1 and resp_data=0, and no strobes are issued.
- States:
  - IDLE: req_ready=1. On accept: fault → RESP; load → LD; store with size 3 → WR; otherwise → RMW_RD.
  - LD: mem_memoryread=1, mem_address=latched addr. At the posedge, resp_data captures the extended result. → RESP.
  - RMW_RD: mem_memoryread=1. At the posedge, capture mem_read_data into a merge register. → WR.
  - WR: mem_memorywrite=1, mem_memoryread=0, mem_address=addr. mem_write_data is the merge register with its low 2^size bytes replaced by the corresponding req_wdata bytes; for size 3 it is req_wdata. → RESP.
  - RESP: resp_valid=1, with resp_data and resp_fault stable. Leave for IDLE on the posedge where resp_ready=1. resp_ready is ignored in all other states.
- Extension: take the low 8×2^size bits of mem_read_data. Sign-extend from the top bit unless req_unsigned, in which case zero-extend. For size 3, req_unsigned has no effect.
- Latency with resp_ready held at 1 (accept at posedge N):
  - Load: resp_valid in cycle N+2.
  - Doubleword store: resp_valid in cycle N+2; write at the end of cycle N+1.
  - Sub-doubleword store: resp_valid in cycle N+3.
  - Fault: resp_valid in cycle N+1.
  - Next accept is possible one cycle after resp_ready is taken.
- Outside RD/RMW_RD/WR, mem_address holds its last value and mem_write_data is 0.
- Never: both strobes high in the same cycle; more than one write per store request.

Optional Feature:
- Macro: MISALIGN_FAULT_EN.
- Defined: at accept, a request also faults if req_addr is not a multiple of 2^size. Same fault path as the range check: no strobes, resp_fault=1, resp_data=0.
- Undefined: misaligned accesses proceed normally, since the memory is byte-granular; only the range check faults.

Test Plan:
- Store double 0x1122334455667788 @0 → one WR cycle. Then load double @0 → 0x1122334455667788, resp_valid at N+2.
- Memory @8..15 = 0xFFFFFFFFFFFFFFFF; store byte 0x5A @8 → RMW_RD then WR with mem_write_data=0xFFFFFFFFFFFFFF5A. Reload double → same value.
- Memory @16 = 0x80F0; load half signed → 0xFFFFFFFFFFFF80F0; load half unsigned → 0x00000000000080F0; load byte signed → 0xFFFFFFFFFFFFFFF0.
- Load @57 (MEM_BYTES=64) → resp_fault=1, resp_data=0, no strobe ever high, resp_valid at N+1. Load @56 → no fault.
- resp_ready held low 5 cycles → resp_valid and data stable, req_ready=0 throughout. Reset asserted in a WR cycle → mem_memorywrite=0 that cycle, memory unchanged, state IDLE.
- With MISALIGN_FAULT_EN: word load @6 → fault. Without it: word load @6 → normal data.
